// File: rtl/clint_mmio_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clint_mmio_arbiter
// Brief    : Round-robin arbiter sharing the CLINT MMIO slave among harts,
//            one registered transaction at a time with a slave timeout.
// Revision : 1.0 - initial release
// ============================================================================
module clint_mmio_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_CORES-1:0]                  req_valid,
    input  logic [NUM_CORES-1:0]                  req_write,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_CORES-1:0][7:0]             req_byte_en,
    output logic [NUM_CORES-1:0]                  req_ready,
    output logic [NUM_CORES-1:0]                  resp_valid,
    output logic [DATA_WIDTH-1:0]                 resp_rdata,
    output logic                                  resp_error,
    output logic [ADDR_WIDTH-1:0]                 mmio_addr,
    output logic [DATA_WIDTH-1:0]                 mmio_write_data,
    output logic [7:0]                            mmio_byte_en,
    output logic                                  mmio_read,
    output logic                                  mmio_write,
    input  logic [DATA_WIDTH-1:0]                 mmio_read_data,
    input  logic                                  mmio_ready,
    input  logic                                  mmio_error
);

    localparam int c_iw = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int c_cw = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_resp  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_iw-1:0]       r_rr_ptr;
    logic [c_iw-1:0]       r_gnt;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_be;
    logic [c_cw-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_any;
    logic [c_iw-1:0]       w_grant;
    logic [NUM_CORES-1:0]  w_grant_oh;
    logic [NUM_CORES-1:0]  w_gnt_oh;
    logic                  w_timeout;

    // Scan offsets from highest to lowest so the smallest offset from rr_ptr wins.
    always_comb begin
        int              v_idx;
        logic [c_iw-1:0] v_sel;
        w_any   = 1'b0;
        w_grant = '0;
        v_idx   = 0;
        v_sel   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            v_idx = int'(r_rr_ptr) + i;
            if (v_idx >= NUM_CORES) v_idx = v_idx - NUM_CORES;
            v_sel = c_iw'(v_idx);
            if (req_valid[v_sel]) begin
                w_any   = 1'b1;
                w_grant = v_sel;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_onehot
            assign w_grant_oh[gi] = (w_grant == c_iw'(gi));
            assign w_gnt_oh[gi]   = (r_gnt == c_iw'(gi));
        end
    endgenerate

    assign w_timeout = (r_cnt == c_cw'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_idle;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_any) w_next_state = c_issue;
            c_issue: if (mmio_ready || w_timeout) w_next_state = c_resp;
            c_resp:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // req_ready is gated by rst_n so requesters never see an accept while in reset.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        mmio_read  = 1'b0;
        mmio_write = 1'b0;
        case (r_state)
            c_idle:  if (w_any && rst_n) req_ready = w_grant_oh;
            c_issue: begin
                mmio_read  = ~r_wr;
                mmio_write = r_wr;
            end
            c_resp:  resp_valid = w_gnt_oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_idle: if (w_any) begin
                    r_gnt   <= w_grant;
                    r_wr    <= req_write[w_grant];
                    r_addr  <= req_addr[w_grant];
                    r_wdata <= req_wdata[w_grant];
                    r_be    <= req_byte_en[w_grant];
                    r_cnt   <= '0;
                end
                c_issue: begin
                    if (mmio_ready) begin
                        r_rdata <= r_wr ? '0 : mmio_read_data;
                        r_err   <= mmio_error;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                c_resp: r_rr_ptr <= (r_gnt == c_iw'(NUM_CORES - 1)) ? '0 : r_gnt + c_iw'(1);
                default: ;
            endcase
        end
    end

    assign mmio_addr       = r_addr;
    assign mmio_write_data = r_wdata;
    assign mmio_byte_en    = r_be;
    assign resp_rdata      = r_rdata;
    assign resp_error      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clint_mmio_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clint_mmio_arbiter
// Brief    : Scoreboard bench for clint_mmio_arbiter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_mmio_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]          req_valid = '0;
    logic [N-1:0]          req_write = '0;
    logic [N-1:0][63:0]    req_addr  = '0;
    logic [N-1:0][63:0]    req_wdata = '0;
    logic [N-1:0][7:0]     req_byte_en = '0;
    logic [N-1:0]          req_ready, resp_valid;
    logic [63:0]           resp_rdata, mmio_addr, mmio_write_data, mmio_read_data;
    logic                  resp_error, mmio_read, mmio_write, mmio_ready, mmio_error;
    logic [7:0]            mmio_byte_en;

    logic        slave_ready = 1'b1;
    logic        slave_err   = 1'b0;
    logic        slave_xor   = 1'b0;
    logic [63:0] slave_rdata = '0;
    assign mmio_read_data = slave_xor ? (slave_rdata ^ mmio_addr) : slave_rdata;
    assign mmio_ready     = slave_ready;
    assign mmio_error     = slave_err;

    clint_mmio_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data), .mmio_byte_en(mmio_byte_en),
        .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_read_data(mmio_read_data),
        .mmio_ready(mmio_ready), .mmio_error(mmio_error)
    );

    typedef struct {logic wr; logic [63:0] addr; logic [63:0] wdata; logic [7:0] be;} req_t;
    typedef struct {int core; int gap;} gnt_t;
    typedef struct {int core; logic [63:0] rdata; logic err; int lat;} rsp_t;

    req_t reqq[N][$];
    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    req_t exp_mmio[$];

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_gnt = -100;
    logic [N-1:0] acc = '0;
    req_t drv_q, m_mmio;
    gnt_t m_gnt;
    rsp_t m_rsp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input int c, input logic wr, input logic [63:0] a,
                            input logic [63:0] d, input logic [7:0] be, input int gap,
                            input logic [63:0] rd, input logic er, input int lat, input logic issued);
        req_t q;
        gnt_t g;
        rsp_t r;
        q.wr = wr; q.addr = a; q.wdata = d; q.be = be;
        reqq[c].push_back(q);
        g.core = c; g.gap = gap;
        exp_gnt.push_back(g);
        r.core = c; r.rdata = rd; r.err = er; r.lat = lat;
        if (lat > 0) exp_rsp.push_back(r);
        if (issued) exp_mmio.push_back(q);
    endtask

    task automatic chk_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_mmio_rw", 64'({mmio_read, mmio_write}), 64'd0);
        check("rst_mmio_addr", mmio_addr, 64'd0);
        check("rst_mmio_wdata", mmio_write_data, 64'd0);
        check("rst_mmio_be", 64'(mmio_byte_en), 64'd0);
    endtask

    function automatic bit busy();
        bit b = (exp_rsp.size() != 0) || (exp_gnt.size() != 0) || (req_valid != '0);
        for (int c = 0; c < N; c++) if (reqq[c].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_drain();
        int k = 0;
        while (busy() && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: got still busy expected idle within 300 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wait_grant();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_ready == '0 && k < 50);
        if (req_ready == '0) begin
            n_vec++; n_bad++;
            $display("FAIL grant_timeout: got no req_ready expected a grant within 50 cycles");
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: holds fields until accepted, then loads its next queued request.
    always @(negedge clk) acc <= rst_n ? (req_valid & req_ready) : '0;
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N; c++) begin
            if (acc[c]) req_valid[c] = 1'b0;
            if (!req_valid[c] && reqq[c].size() != 0) begin
                drv_q = reqq[c].pop_front();
                req_write[c]   = drv_q.wr;
                req_addr[c]    = drv_q.addr;
                req_wdata[c]   = drv_q.wdata;
                req_byte_en[c] = drv_q.be;
                req_valid[c]   = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0 && resp_valid != '0)
                check("ready_resp_exclusive", 64'({req_ready, resp_valid}), 64'd0);
            if (mmio_read && mmio_write)
                check("mmio_rw_exclusive", 64'd3, 64'd1);
            if (resp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=%b expected none", resp_valid);
                end else begin
                    m_rsp = exp_rsp.pop_front();
                    check("resp_valid", 64'(resp_valid), 64'd1 << m_rsp.core);
                    check("resp_rdata", resp_rdata, m_rsp.rdata);
                    check("resp_error", 64'(resp_error), 64'(m_rsp.err));
                    check("resp_latency", 64'(cyc - last_gnt), 64'(m_rsp.lat));
                end
            end
            if (req_ready != '0) begin
                if (exp_gnt.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_grant: got req_ready=%b expected none", req_ready);
                end else begin
                    m_gnt = exp_gnt.pop_front();
                    check("grant", 64'(req_ready), 64'd1 << m_gnt.core);
                    if (m_gnt.gap >= 0) check("grant_gap", 64'(cyc - last_gnt), 64'(m_gnt.gap));
                end
                last_gnt = cyc;
            end
            if ((mmio_read || mmio_write) && mmio_ready) begin
                if (exp_mmio.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_mmio: got access to %h expected none", mmio_addr);
                end else begin
                    m_mmio = exp_mmio.pop_front();
                    check("mmio_write", 64'(mmio_write), 64'(m_mmio.wr));
                    check("mmio_read", 64'(mmio_read), 64'(!m_mmio.wr));
                    check("mmio_addr", mmio_addr, m_mmio.addr);
                    check("mmio_wdata", mmio_write_data, m_mmio.wdata);
                    check("mmio_be", 64'(mmio_byte_en), 64'(m_mmio.be));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous requests from reset: served 0,1,2,3, every 3 cycles
        slave_xor = 1'b1; slave_rdata = 64'h5000_0000_0000_0000;
        push_req(0, 0, 64'h100, 0, 8'h00, -1, 64'h5000_0000_0000_0100, 0, 2, 1);
        push_req(1, 0, 64'h200, 0, 8'h00,  3, 64'h5000_0000_0000_0200, 0, 2, 1);
        push_req(2, 0, 64'h300, 0, 8'h00,  3, 64'h5000_0000_0000_0300, 0, 2, 1);
        push_req(3, 0, 64'h400, 0, 8'h00,  3, 64'h5000_0000_0000_0400, 0, 2, 1);
        wait_drain();

        // Single read of mtime by core 1
        slave_xor = 1'b0; slave_rdata = 64'h1234;
        push_req(1, 0, 64'h0200_BFF8, 0, 8'hFF, -1, 64'h1234, 0, 2, 1);
        wait_drain();

        // Fairness: cores 0 and 2 back to back (rr_ptr is 2 here)
        slave_xor = 1'b1; slave_rdata = 64'h0;
        push_req(2, 0, 64'h20, 0, 8'hFF, -1, 64'h20, 0, 2, 1);
        push_req(0, 0, 64'h10, 0, 8'hFF,  3, 64'h10, 0, 2, 1);
        push_req(2, 0, 64'h21, 0, 8'hFF,  3, 64'h21, 0, 2, 1);
        push_req(0, 0, 64'h11, 0, 8'hFF,  3, 64'h11, 0, 2, 1);
        push_req(2, 0, 64'h22, 0, 8'hFF,  3, 64'h22, 0, 2, 1);
        push_req(0, 0, 64'h12, 0, 8'hFF,  3, 64'h12, 0, 2, 1);
        wait_drain();

        // Write pass-through: read data from the slave must not leak into the response
        slave_xor = 1'b0; slave_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        push_req(3, 1, 64'h0200_C018, 64'hDEAD_BEEF, 8'h0F, -1, 64'h0, 0, 2, 1);
        wait_drain();

        // Slave error flag passes through on a read
        slave_rdata = 64'h77; slave_err = 1'b1;
        push_req(0, 0, 64'h0200_0000, 0, 8'hFF, -1, 64'h77, 1, 2, 1);
        wait_drain();
        slave_err = 1'b0;

        // Timeout: slave never ready, 5 ISSUE cycles then error response
        slave_ready = 1'b0; slave_rdata = 64'hABCD;
        push_req(3, 0, 64'h0200_4000, 0, 8'hFF, -1, 64'h0, 1, 6, 0);
        wait_drain();

        // Ready on the 5th ISSUE cycle wins over the timeout
        slave_rdata = 64'hBEEF;
        push_req(2, 0, 64'h0200_4008, 0, 8'hFF, -1, 64'hBEEF, 0, 6, 1);
        wait_grant();
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 slave_ready = 1'b1;
        @(posedge clk);
        #1 slave_ready = 1'b0;
        wait_drain();

        // Reset mid-ISSUE aborts core 1; afterwards lowest requester wins
        push_req(1, 0, 64'h0200_0100, 0, 8'hFF, -1, 64'h0, 0, 0, 0);
        wait_grant();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        slave_ready = 1'b1; slave_xor = 1'b1; slave_rdata = 64'h0;
        push_req(3, 0, 64'h0200_0010, 0, 8'hFF, -1, 64'h0200_0010, 0, 2, 1);
        push_req(2, 0, 64'h0200_0008, 0, 8'hFF, -1, 64'h0200_0008, 0, 2, 1);
        exp_gnt.delete();
        exp_rsp.delete();
        exp_mmio.delete();
        begin
            gnt_t g;
            rsp_t r;
            req_t q;
            g.core = 2; g.gap = -1; exp_gnt.push_back(g);
            g.core = 3; g.gap = 3;  exp_gnt.push_back(g);
            r.core = 2; r.rdata = 64'h0200_0008; r.err = 0; r.lat = 2; exp_rsp.push_back(r);
            r.core = 3; r.rdata = 64'h0200_0010; r.err = 0; r.lat = 2; exp_rsp.push_back(r);
            q.wr = 0; q.wdata = 0; q.be = 8'hFF;
            q.addr = 64'h0200_0008; exp_mmio.push_back(q);
            q.addr = 64'h0200_0010; exp_mmio.push_back(q);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain();

        check("leftover_expectations", 64'(exp_rsp.size() + exp_gnt.size() + exp_mmio.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
